// File: rtl/c3lib_gate_en_seq_pkg.sv
// Shared types and defaults for the gate-enable sequencer.
// No logic; declarations only.
// No flow control; consumed by c3lib_gate_en_seq and its counter.
package c3lib_gate_en_seq_pkg;

  localparam int GS_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    GS_OFF      = 2'd0,
    GS_ON_WAIT  = 2'd1,
    GS_ON       = 2'd2,
    GS_OFF_WAIT = 2'd3
  } gate_seq_st_e;

endpackage

// File: rtl/c3lib_gate_en_seq_cnt.sv
// Loadable saturating down-counter timing the on/off delays of the sequencer.
// Latency: load or decrement visible one cycle after the edge; cnt_is_one is combinational from cnt.
// No backpressure; load has priority over dec, and the count stops at 0 (never wraps).
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset (cnt -> 0)
//   load, load_val  load the counter with load_val
//   dec             decrement by one when nonzero
//   cnt, cnt_is_one current count and (cnt == 1) decode
module c3lib_gate_en_seq_cnt
  import c3lib_gate_en_seq_pkg::*;
#(
  parameter int CNT_W = GS_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_is_one
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign cnt_is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/c3lib_gate_en_seq.sv
// Sequences the registered enable for in1 of a downstream AND2 gating cell, with programmable on/off delays.
// Latency: en_req edge sampled at edge N -> gate_en changes after edge N+1+cfg_*_dly.
// No backpressure; en_ack (== gate_en) is the 4-phase handshake back to the requester.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   en_req                     level request, 1 = open gate, 0 = close gate
//   cfg_on_dly, cfg_off_dly    delays, sampled only on entry to the matching wait state
//   gate_en, en_ack            flop-driven enable and its acknowledge copy
//   busy                       high while in ON_WAIT or OFF_WAIT
// Optional: C3LIB_GATE_EN_SEQ_OVRD_EN adds ovrd_en/ovrd_val, forcing gate_en to ovrd_val
// (one-cycle latency) while holding the FSM in OFF with the counter cleared.
module c3lib_gate_en_seq
  import c3lib_gate_en_seq_pkg::*;
#(
  parameter int CNT_W = GS_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_req,
  input  logic [CNT_W-1:0] cfg_on_dly,
  input  logic [CNT_W-1:0] cfg_off_dly,
`ifdef C3LIB_GATE_EN_SEQ_OVRD_EN
  input  logic             ovrd_en,
  input  logic             ovrd_val,
`endif
  output logic             gate_en,
  output logic             en_ack,
  output logic             busy
);

  gate_seq_st_e     st_q, st_nxt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_is_one;
  logic             gate_nxt;

  c3lib_gate_en_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_val   (cnt_load_val),
    .dec        (cnt_dec),
    .cnt        (cnt),
    .cnt_is_one (cnt_is_one)
  );

  assign busy    = (st_q == GS_ON_WAIT) || (st_q == GS_OFF_WAIT);
  assign cnt_dec = busy && (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= GS_OFF;
    end else begin
      st_q <= st_nxt;
    end
  end

  always_comb begin
    st_nxt       = st_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (st_q)
      GS_OFF: begin
        if (en_req) begin
          if (cfg_on_dly != '0) begin
            st_nxt       = GS_ON_WAIT;
            cnt_load     = 1'b1;
            cnt_load_val = cfg_on_dly;
          end else begin
            st_nxt = GS_ON;
          end
        end
      end
      GS_ON_WAIT: begin
        // Request withdrawn before the gate opened: abort and clear the count.
        if (!en_req) begin
          st_nxt   = GS_OFF;
          cnt_load = 1'b1;
        end else if (cnt_is_one) begin
          st_nxt = GS_ON;
        end
      end
      GS_ON: begin
        if (!en_req) begin
          if (cfg_off_dly != '0) begin
            st_nxt       = GS_OFF_WAIT;
            cnt_load     = 1'b1;
            cnt_load_val = cfg_off_dly;
          end else begin
            st_nxt = GS_OFF;
          end
        end
      end
      GS_OFF_WAIT: begin
        // Re-request during drain: reopen without ever dropping the gate.
        if (en_req) begin
          st_nxt   = GS_ON;
          cnt_load = 1'b1;
        end else if (cnt_is_one) begin
          st_nxt = GS_OFF;
        end
      end
      default: st_nxt = GS_OFF;
    endcase
`ifdef C3LIB_GATE_EN_SEQ_OVRD_EN
    if (ovrd_en) begin
      st_nxt       = GS_OFF;
      cnt_load     = 1'b1;
      cnt_load_val = '0;
    end
`endif
  end

  // gate_en is a flop of the decoded state, so it can never glitch even
  // if en_req toggles every cycle.
  always_comb begin
    gate_nxt = (st_q == GS_ON) || (st_q == GS_OFF_WAIT);
`ifdef C3LIB_GATE_EN_SEQ_OVRD_EN
    if (ovrd_en) begin
      gate_nxt = ovrd_val;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_en <= 1'b0;
    end else begin
      gate_en <= gate_nxt;
    end
  end

  assign en_ack = gate_en;

endmodule

// File: tb/tb_c3lib_gate_en_seq.sv
module tb_c3lib_gate_en_seq;
  import c3lib_gate_en_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       en_req;
  logic [7:0] cfg_on_dly;
  logic [7:0] cfg_off_dly;
`ifdef C3LIB_GATE_EN_SEQ_OVRD_EN
  logic       ovrd_en;
  logic       ovrd_val;
`endif
  logic       gate_en;
  logic       en_ack;
  logic       busy;

  int n_chk;
  int n_fail;

  c3lib_gate_en_seq #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_req      (en_req),
    .cfg_on_dly  (cfg_on_dly),
    .cfg_off_dly (cfg_off_dly),
`ifdef C3LIB_GATE_EN_SEQ_OVRD_EN
    .ovrd_en     (ovrd_en),
    .ovrd_val    (ovrd_val),
`endif
    .gate_en     (gate_en),
    .en_ack      (en_ack),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    en_req      = 1'b1;
    cfg_on_dly  = 8'd2;
    cfg_off_dly = 8'd0;
`ifdef C3LIB_GATE_EN_SEQ_OVRD_EN
    ovrd_en     = 1'b0;
    ovrd_val    = 1'b0;
`endif

    // T1: reset held with en_req high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_rst_gate", {7'd0, gate_en}, 8'd0);
      chk("t1_rst_ack", {7'd0, en_ack}, 8'd0);
      chk("t1_rst_busy", {7'd0, busy}, 8'd0);
    end
    rst = 1'b0;
    step();                                   // OFF -> ON_WAIT (cnt=2)
    chk("t1_busy_start", {7'd0, busy}, 8'd1);
    chk("t1_gate_start", {7'd0, gate_en}, 8'd0);
    step();
    step();                                   // -> ON
    chk("t1_state_on", 8'(dut.st_q), 8'(GS_ON));
    chk("t1_gate_pre", {7'd0, gate_en}, 8'd0);
    step();
    chk("t1_gate_open", {7'd0, gate_en}, 8'd1);
    chk("t1_ack_open", {7'd0, en_ack}, 8'd1);

    // T3: zero delays, one-cycle latency both directions
    en_req = 1'b0;
    step();
    chk("t3_fall_m0", {7'd0, gate_en}, 8'd1);
    step();
    chk("t3_fall_m1", {7'd0, gate_en}, 8'd0);
    chk("t3_busy_off", {7'd0, busy}, 8'd0);
    cfg_on_dly = 8'd0;
    en_req = 1'b1;
    step();
    chk("t3_rise_n0", {7'd0, gate_en}, 8'd0);
    chk("t3_rise_busy", {7'd0, busy}, 8'd0);
    step();
    chk("t3_rise_n1", {7'd0, gate_en}, 8'd1);
    en_req = 1'b0;
    step();
    chk("t3_fall2_m0", {7'd0, gate_en}, 8'd1);
    step();
    chk("t3_fall2_m1", {7'd0, gate_en}, 8'd0);

    // T2: on_dly=4, off_dly=2
    cfg_on_dly  = 8'd4;
    cfg_off_dly = 8'd2;
    en_req = 1'b1;
    step();                                   // edge N
    chk("t2_busy_n", {7'd0, busy}, 8'd1);
    chk("t2_gate_n", {7'd0, gate_en}, 8'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t2_gate_wait", {7'd0, gate_en}, 8'd0);
    end
    step();                                   // edge N+5
    chk("t2_gate_n5", {7'd0, gate_en}, 8'd1);
    chk("t2_busy_n5", {7'd0, busy}, 8'd0);
    step();
    step();
    en_req = 1'b0;
    step();                                   // edge M
    chk("t2_offw_busy", {7'd0, busy}, 8'd1);
    chk("t2_gate_m0", {7'd0, gate_en}, 8'd1);
    step();
    chk("t2_gate_m1", {7'd0, gate_en}, 8'd1);
    step();
    chk("t2_gate_m2", {7'd0, gate_en}, 8'd1);
    step();                                   // edge M+3
    chk("t2_gate_m3", {7'd0, gate_en}, 8'd0);
    chk("t2_ack_m3", {7'd0, en_ack}, 8'd0);

    // cfg_on_dly change during ON_WAIT is ignored
    cfg_on_dly = 8'd3;
    en_req = 1'b1;
    step();                                   // N: loads 3
    cfg_on_dly = 8'd100;
    step();
    step();
    step();                                   // N+3: -> ON
    chk("cfg_on_n3", {7'd0, gate_en}, 8'd0);
    step();
    chk("cfg_on_n4", {7'd0, gate_en}, 8'd1);

    // Reset while open closes the gate on the next edge
    rst = 1'b1;
    step();
    chk("rst_mid_gate", {7'd0, gate_en}, 8'd0);
    chk("rst_mid_state", 8'(dut.st_q), 8'(GS_OFF));
    rst = 1'b0;
    en_req = 1'b0;
    step();

    // T4: aborted open
    cfg_on_dly = 8'd6;
    en_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_busy", {7'd0, busy}, 8'd1);
      chk("t4_gate", {7'd0, gate_en}, 8'd0);
    end
    en_req = 1'b0;
    step();
    chk("t4_busy_end", {7'd0, busy}, 8'd0);
    chk("t4_state", 8'(dut.st_q), 8'(GS_OFF));
    step();
    chk("t4_gate_end", {7'd0, gate_en}, 8'd0);
    chk("t4_ack_end", {7'd0, en_ack}, 8'd0);

    // en_req toggling every cycle with on_dly=1 never opens the gate
    cfg_on_dly = 8'd1;
    for (int i = 0; i < 10; i++) begin
      en_req = (i % 2 == 0);
      step();
      chk("toggle_gate", {7'd0, gate_en}, 8'd0);
    end
    en_req = 1'b0;
    step();
    chk("toggle_state", 8'(dut.st_q), 8'(GS_OFF));

    // T5: re-open during drain
    cfg_on_dly  = 8'd0;
    cfg_off_dly = 8'd5;
    en_req = 1'b1;
    step();
    step();
    chk("t5_open", {7'd0, gate_en}, 8'd1);
    en_req = 1'b0;
    step();                                   // M
    chk("t5_state_offw", 8'(dut.st_q), 8'(GS_OFF_WAIT));
    chk("t5_gate_m0", {7'd0, gate_en}, 8'd1);
    step();
    chk("t5_gate_m1", {7'd0, gate_en}, 8'd1);
    en_req = 1'b1;
    step();                                   // M+2
    chk("t5_state_on", 8'(dut.st_q), 8'(GS_ON));
    chk("t5_gate_m2", {7'd0, gate_en}, 8'd1);
    step();
    chk("t5_gate_m3", {7'd0, gate_en}, 8'd1);
    chk("t5_busy_m3", {7'd0, busy}, 8'd0);

    // cfg_off_dly change during OFF_WAIT is ignored
    cfg_off_dly = 8'd3;
    en_req = 1'b0;
    step();                                   // M: loads 3
    cfg_off_dly = 8'd200;
    step();
    step();
    step();                                   // M+3: -> OFF
    chk("cfg_off_m3_gate", {7'd0, gate_en}, 8'd1);
    chk("cfg_off_m3_state", 8'(dut.st_q), 8'(GS_OFF));
    step();
    chk("cfg_off_m4_gate", {7'd0, gate_en}, 8'd0);

`ifdef C3LIB_GATE_EN_SEQ_OVRD_EN
    // T6: override
    ovrd_en  = 1'b1;
    ovrd_val = 1'b1;
    step();
    chk("t6_ovrd_gate", {7'd0, gate_en}, 8'd1);
    chk("t6_ovrd_ack", {7'd0, en_ack}, 8'd1);
    chk("t6_ovrd_busy", {7'd0, busy}, 8'd0);
    ovrd_en = 1'b0;
    step();
    chk("t6_rel_gate", {7'd0, gate_en}, 8'd0);
    chk("t6_rel_busy", {7'd0, busy}, 8'd0);
    ovrd_en  = 1'b1;
    ovrd_val = 1'b0;
    en_req   = 1'b1;
    step();
    step();
    chk("t6_hold_state", 8'(dut.st_q), 8'(GS_OFF));
    chk("t6_hold_gate", {7'd0, gate_en}, 8'd0);
    ovrd_en = 1'b0;
    step();
    step();
    chk("t6_restart_gate", {7'd0, gate_en}, 8'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
